tile_scan_generator: RTL and testbench



---
 rtl/tile_scan_pkg.sv | 45 ++++
 rtl/pipe_delay_line.sv | 42 ++++
 rtl/tile_scan_generator.sv | 182 ++++++++++++++++++
 tb/tb_tile_scan_generator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_scan_pkg.sv
// tile_scan_pkg
//   Shared constants for the tile scan generator: 1080p timing defaults,
//   tile geometry, the tile address width, and the packed layout of the
//   per-pixel timing flags.
//   Optional feature macro used by the top: TILE_SCAN_FRAME_CNT_EN.
package tile_scan_pkg;

    // 1080p60 timing defaults
    localparam int unsigned H_ACTIVE_DEF = 1920;
    localparam int unsigned H_FRONT_DEF  = 88;
    localparam int unsigned H_SYNC_DEF   = 44;
    localparam int unsigned H_BACK_DEF   = 148;
    localparam int unsigned V_ACTIVE_DEF = 1080;
    localparam int unsigned V_FRONT_DEF  = 4;
    localparam int unsigned V_SYNC_DEF   = 5;
    localparam int unsigned V_BACK_DEF   = 36;

    // Tile map geometry
    localparam int unsigned TILE_SHIFT_DEF = 4;
    localparam int unsigned MAP_COLS_DEF   = 120;
    localparam int unsigned MAP_ROWS       = 68;
    localparam int unsigned ADDR_W         = 13;
    localparam int unsigned FRAME_CNT_W    = 8;

    // Sum of the four segments of one timing axis.
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned front,
                                                 input int unsigned sync,
                                                 input int unsigned back);
        return active + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL_DEF =
        timing_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL_DEF =
        timing_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    // Timing flags that travel down the delay line together.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_flags_t;

endpackage

// File: rtl/pipe_delay_line.sv
// pipe_delay_line
//   Fixed-latency shift register. o_data equals i_data from DEPTH cycles
//   earlier; a synchronous reset loads every stage with RESET_VAL.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_data   WIDTH-bit input word
//   o_data   WIDTH-bit word delayed by DEPTH cycles
module pipe_delay_line #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!i_rst_n) begin
                stage_q[i] <= RESET_VAL;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_scan_generator.sv
// tile_scan_generator
//   Raster timing and tile address generator feeding background_generator.
//   Scans h/v counters, registers active/sync/frame-start and the tile
//   address (row_base + col, no multiplier), and delays the sync, active
//   and in-tile pixel offsets by PIPE_DELAY cycles to line up with the
//   registered tile data downstream.
// Ports:
//   i_clk          pixel clock
//   i_rst_n        synchronous active-low reset
//   o_address      tile index row*MAP_COLS+col, 0 in blanking (undelayed)
//   o_active       pixel visible (undelayed)
//   o_frame_start  one-cycle pulse at h=0, v=0
//   o_hsync_d      hsync, delayed PIPE_DELAY
//   o_vsync_d      vsync, delayed PIPE_DELAY
//   o_active_d     active, delayed PIPE_DELAY
//   o_px_x_d       pixel column inside tile, delayed PIPE_DELAY
//   o_px_y_d       pixel row inside tile, delayed PIPE_DELAY
//   o_frame_cnt    frame counter (only with TILE_SCAN_FRAME_CNT_EN)
// Optional macro: TILE_SCAN_FRAME_CNT_EN adds o_frame_cnt.
module tile_scan_generator
    import tile_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter int unsigned TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int unsigned MAP_COLS   = MAP_COLS_DEF,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_W-1:0]     o_address,
    output logic                  o_active,
    output logic                  o_frame_start,
    output logic                  o_hsync_d,
    output logic                  o_vsync_d,
    output logic                  o_active_d,
    output logic [TILE_SHIFT-1:0] o_px_x_d,
    output logic [TILE_SHIFT-1:0] o_px_y_d
`ifdef TILE_SCAN_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam int unsigned DL_W = 3 + 2 * TILE_SHIFT;
    localparam logic [DL_W-1:0] DL_RESET = {~SYNC_POL, ~SYNC_POL, 1'b0, {(2*TILE_SHIFT){1'b0}}};

    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic                  frame_start_q, frame_start_d;
    sync_flags_t           flags_q, flags_d;
    logic [TILE_SHIFT-1:0] px_x_q, px_x_d;
    logic [TILE_SHIFT-1:0] px_y_q, px_y_d;
    logic                  h_last, v_last;
    logic [ADDR_W-1:0]     col;
    logic [DL_W-1:0]       dl_out;

    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        v_last  = (v_cnt_q == V_LAST);
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        flags_d.active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        flags_d.hsync  = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        flags_d.vsync  = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
        px_x_d         = h_cnt_q[TILE_SHIFT-1:0];
        px_y_d         = v_cnt_q[TILE_SHIFT-1:0];

        // row_base tracks (v >> TILE_SHIFT) * MAP_COLS: it steps after the last
        // visible pixel of a tile's bottom line, so the next line sees the new
        // row while this line still addresses the old one.
        row_base_d = row_base_q;
        if (h_last && v_last) begin
            row_base_d = '0;
        end else if ((h_cnt_q == H_ACT_LAST) && (v_cnt_q < V_ACT_END) &&
                     (&v_cnt_q[TILE_SHIFT-1:0])) begin
            row_base_d = row_base_q + ADDR_W'(MAP_COLS);
        end

        col       = ADDR_W'(h_cnt_q >> TILE_SHIFT);
        address_d = flags_d.active ? row_base_q + col : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            row_base_q    <= '0;
            address_q     <= '0;
            frame_start_q <= 1'b0;
            flags_q       <= '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};
            px_x_q        <= '0;
            px_y_q        <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_base_q    <= row_base_d;
            address_q     <= address_d;
            frame_start_q <= frame_start_d;
            flags_q       <= flags_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
        end
    end

    assign o_address     = address_q;
    assign o_active      = flags_q.active;
    assign o_frame_start = frame_start_q;

    pipe_delay_line #(
        .WIDTH    (DL_W),
        .DEPTH    (PIPE_DELAY),
        .RESET_VAL(DL_RESET)
    ) u_delay (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_data ({flags_q, px_x_q, px_y_q}),
        .o_data (dl_out)
    );

    assign {o_hsync_d, o_vsync_d, o_active_d, o_px_x_d, o_px_y_d} = dl_out;

`ifdef TILE_SCAN_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_seen_q, frame_seen_d;

    // The first frame after reset is not counted; the count moves on the
    // same cycle o_frame_start goes high.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        frame_seen_d = frame_seen_q;
        if (frame_start_d) begin
            if (frame_seen_q) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            frame_seen_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame_cnt_q  <= '0;
            frame_seen_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_tile_scan_generator.sv
`timescale 1ns/1ps
// Two instances: the default 1080p build (table of hand-derived points on
// the first 18 lines) and a scaled raster with PIPE_DELAY=3 checked every
// cycle against an independent model through a scoreboard queue.
module tb_tile_scan_generator;

    localparam int S_HA = 40, S_HF = 4, S_HS = 3, S_HB = 5, S_HT = 52;
    localparam int S_VA = 22, S_VF = 2, S_VS = 2, S_VB = 3, S_VT = 29;
    localparam int S_TS = 2, S_MC = 10, S_PD = 3;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int B_HT = 2200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] b_addr, s_addr;
    logic        b_act, b_fs, b_hs_d, b_vs_d, b_act_d;
    logic        s_act, s_fs, s_hs_d, s_vs_d, s_act_d;
    logic [3:0]  b_px_x_d, b_px_y_d;
    logic [1:0]  s_px_x_d, s_px_y_d;
    logic [7:0]  b_fc, s_fc;

    tile_scan_generator u_big (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_address    (b_addr),
        .o_active     (b_act),
        .o_frame_start(b_fs),
        .o_hsync_d    (b_hs_d),
        .o_vsync_d    (b_vs_d),
        .o_active_d   (b_act_d),
        .o_px_x_d     (b_px_x_d),
        .o_px_y_d     (b_px_y_d)
`ifdef TILE_SCAN_FRAME_CNT_EN
        ,
        .o_frame_cnt  (b_fc)
`endif
    );

    tile_scan_generator #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .TILE_SHIFT(S_TS), .MAP_COLS(S_MC), .SYNC_POL(1'b1), .PIPE_DELAY(S_PD)
    ) u_small (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_address    (s_addr),
        .o_active     (s_act),
        .o_frame_start(s_fs),
        .o_hsync_d    (s_hs_d),
        .o_vsync_d    (s_vs_d),
        .o_active_d   (s_act_d),
        .o_px_x_d     (s_px_x_d),
        .o_px_y_d     (s_px_y_d)
`ifdef TILE_SCAN_FRAME_CNT_EN
        ,
        .o_frame_cnt  (s_fc)
`endif
    );

`ifndef TILE_SCAN_FRAME_CNT_EN
    assign b_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard for the scaled instance ----------------
    typedef struct packed {
        logic [12:0] addr;
        logic        act;
        logic        fs;
        logic        hs_d;
        logic        vs_d;
        logic        act_d;
        logic [1:0]  px_x_d;
        logic [1:0]  px_y_d;
        logic [7:0]  fc;
    } s_obs_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [1:0] px;
        logic [1:0] py;
    } s_pipe_t;

    s_obs_t sb_q[$];

    initial begin : model
        int      mh, mv;
        s_pipe_t hist [S_PD];
        s_pipe_t u;
        s_obs_t  e;
        logic [7:0] fc;
        bit      seen;
        mh = 0; mv = 0; fc = 8'd0; seen = 1'b0;
        for (int i = 0; i < S_PD; i++) hist[i] = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mh = 0; mv = 0; fc = 8'd0; seen = 1'b0;
                for (int i = 0; i < S_PD; i++) hist[i] = '0;
                e = '0;
            end else begin
                u.act = (mh < S_HA) && (mv < S_VA);
                u.hs  = (mh >= S_HA + S_HF) && (mh < S_HA + S_HF + S_HS);
                u.vs  = (mv >= S_VA + S_VF) && (mv < S_VA + S_VF + S_VS);
                u.px  = 2'(mh % 4);
                u.py  = 2'(mv % 4);
                e.addr = u.act ? 13'((mv / 4) * S_MC + mh / 4) : 13'd0;
                e.act  = u.act;
                e.fs   = (mh == 0) && (mv == 0);
`ifdef TILE_SCAN_FRAME_CNT_EN
                if (e.fs) begin
                    if (seen) fc = fc + 8'd1;
                    seen = 1'b1;
                end
`endif
                e.fc     = fc;
                e.hs_d   = hist[S_PD-1].hs;
                e.vs_d   = hist[S_PD-1].vs;
                e.act_d  = hist[S_PD-1].act;
                e.px_x_d = hist[S_PD-1].px;
                e.px_y_d = hist[S_PD-1].py;
                for (int i = S_PD - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = u;
                mh++;
                if (mh == S_HT) begin
                    mh = 0;
                    mv = (mv == S_VT - 1) ? 0 : mv + 1;
                end
            end
            sb_q.push_back(e);
        end
    end

    initial begin : sb_check
        s_obs_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a.addr = s_addr;   a.act = s_act;     a.fs = s_fs;
                a.hs_d = s_hs_d;   a.vs_d = s_vs_d;   a.act_d = s_act_d;
                a.px_x_d = s_px_x_d; a.px_y_d = s_px_y_d; a.fc = s_fc;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb_small t=%0t got addr=%0d act=%b fs=%b hs=%b vs=%b actd=%b px=%0d py=%0d fc=%0d expected addr=%0d act=%b fs=%b hs=%b vs=%b actd=%b px=%0d py=%0d fc=%0d",
                             $time, a.addr, a.act, a.fs, a.hs_d, a.vs_d, a.act_d, a.px_x_d,
                             a.px_y_d, a.fc, e.addr, e.act, e.fs, e.hs_d, e.vs_d, e.act_d,
                             e.px_x_d, e.px_y_d, e.fc);
                end
            end
        end
    end

    // ---------------- table vectors for the 1080p instance ----------------
    // Sample at pixel (h, v); *_d fields describe pixel h-1 (PIPE_DELAY=1).
    typedef struct {
        int          h;
        int          v;
        logic [12:0] addr;
        logic        act;
        logic        fs;
        logic        hs_d;
        logic        act_d;
        logic [3:0]  px_x_d;
    } vec_t;

    vec_t tbl [14];

    initial begin : main
        int cur, delta, n, w;
        tbl[0]  = '{h: 0,    v: 0,  addr: 0,   act: 1, fs: 1, hs_d: 0, act_d: 0, px_x_d: 0};
        tbl[1]  = '{h: 1,    v: 0,  addr: 0,   act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 0};
        tbl[2]  = '{h: 20,   v: 0,  addr: 1,   act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 3};
        tbl[3]  = '{h: 1919, v: 0,  addr: 119, act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 14};
        tbl[4]  = '{h: 1920, v: 0,  addr: 0,   act: 0, fs: 0, hs_d: 0, act_d: 1, px_x_d: 15};
        tbl[5]  = '{h: 2008, v: 0,  addr: 0,   act: 0, fs: 0, hs_d: 0, act_d: 0, px_x_d: 7};
        tbl[6]  = '{h: 2009, v: 0,  addr: 0,   act: 0, fs: 0, hs_d: 1, act_d: 0, px_x_d: 8};
        tbl[7]  = '{h: 2052, v: 0,  addr: 0,   act: 0, fs: 0, hs_d: 1, act_d: 0, px_x_d: 3};
        tbl[8]  = '{h: 2053, v: 0,  addr: 0,   act: 0, fs: 0, hs_d: 0, act_d: 0, px_x_d: 4};
        tbl[9]  = '{h: 0,    v: 1,  addr: 0,   act: 1, fs: 0, hs_d: 0, act_d: 0, px_x_d: 7};
        tbl[10] = '{h: 35,   v: 15, addr: 2,   act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 2};
        tbl[11] = '{h: 0,    v: 16, addr: 120, act: 1, fs: 0, hs_d: 0, act_d: 0, px_x_d: 7};
        tbl[12] = '{h: 1919, v: 16, addr: 239, act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 14};
        tbl[13] = '{h: 100,  v: 17, addr: 126, act: 1, fs: 0, hs_d: 0, act_d: 1, px_x_d: 3};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_b_addr", b_addr, 0);
        check("rst_b_active", b_act, 0);
        check("rst_b_frame_start", b_fs, 0);
        check("rst_b_hsync_d", b_hs_d, 0);
        check("rst_b_vsync_d", b_vs_d, 0);
        check("rst_s_active_d", s_act_d, 0);
        rst_n = 1'b1;
        cur = 0;

        for (int i = 0; i < 14; i++) begin
            repeat (tbl[i].v * B_HT + tbl[i].h + 1 - cur) @(negedge clk);
            cur = tbl[i].v * B_HT + tbl[i].h + 1;
            check($sformatf("tbl%0d_addr", i), b_addr, tbl[i].addr);
            check($sformatf("tbl%0d_active", i), b_act, tbl[i].act);
            check($sformatf("tbl%0d_frame_start", i), b_fs, tbl[i].fs);
            check($sformatf("tbl%0d_hsync_d", i), b_hs_d, tbl[i].hs_d);
            check($sformatf("tbl%0d_active_d", i), b_act_d, tbl[i].act_d);
            check($sformatf("tbl%0d_px_x_d", i), b_px_x_d, tbl[i].px_x_d);
        end

        // Bring the scaled raster to h=25, v=13 and reset mid-frame.
        delta = (13 * S_HT + 25 - ((cur - 1) % S_FRAME) + S_FRAME) % S_FRAME;
        repeat (delta) @(negedge clk);
        check("pre_reset_s_addr", s_addr, (13 / 4) * S_MC + 25 / 4);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_s_active", s_act, 0);
        check("mid_rst_s_addr", s_addr, 0);
        check("mid_rst_b_active_d", b_act_d, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("rel%0d_s_frame_start", k), s_fs, (k == 1));
            check($sformatf("rel%0d_s_active", k), s_act, 1);
            check($sformatf("rel%0d_s_addr", k), s_addr, 0);
            check($sformatf("rel%0d_s_active_d", k), s_act_d, (k > S_PD));
            check($sformatf("rel%0d_s_hsync_d", k), s_hs_d, 0);
            check($sformatf("rel%0d_s_vsync_d", k), s_vs_d, 0);
            check($sformatf("rel%0d_b_frame_start", k), b_fs, (k == 1));
            check($sformatf("rel%0d_b_active_d", k), b_act_d, (k > 1));
            check($sformatf("rel%0d_b_hsync_d", k), b_hs_d, 0);
            check($sformatf("rel%0d_s_frame_cnt", k), s_fc, 0);
            check($sformatf("rel%0d_b_frame_cnt", k), b_fc, 0);
        end
        cur = 4;

        // Frame period of the scaled raster.
        n = 0;
        while (s_fs !== 1'b1 && n < 2 * S_FRAME) begin
            @(negedge clk);
            n++;
        end
        check("s_frame_period", cur + n - 1, S_FRAME);

        // Sync pulse widths.
        n = 0;
        while (s_hs_d !== 1'b1 && n < 4 * S_HT) begin @(negedge clk); n++; end
        w = 0;
        while (s_hs_d === 1'b1 && w < 4 * S_HT) begin @(negedge clk); w++; end
        check("s_hsync_width", w, S_HS);
        n = 0;
        while (s_vs_d !== 1'b1 && n < 2 * S_FRAME) begin @(negedge clk); n++; end
        w = 0;
        while (s_vs_d === 1'b1 && w < 2 * S_FRAME) begin @(negedge clk); w++; end
        check("s_vsync_width", w, S_VS * S_HT);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
